// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multicycle MIPS-32 main control FSM with req/ready memory handshake
module mc_controller #(
  parameter bit ENABLE_ADDI = 1'b1,
  parameter bit ENABLE_JUMP = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       memwrite,
  output logic       iord,
  output logic       irwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_RESET   = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADR  = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_RTYPEEX = 4'd7,
    S_RTYPEWB = 4'd8,
    S_BEQEX   = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ADDIWB  = 4'd11,
    S_JEX     = 4'd12
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   w_pcwrite;
  logic   w_branch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_RESET;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = S_FETCH;
    w_pcwrite  = 1'b0;
    w_branch   = 1'b0;
    mem_req    = 1'b0;
    memwrite   = 1'b0;
    iord       = 1'b0;
    irwrite    = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    aluop      = 2'b00;
    pcsrc      = 2'b00;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    case (r_state)
      S_RESET: w_next = S_FETCH;
      S_FETCH: begin
        // PC+4 is computed every cycle but only committed with the IR load.
        mem_req   = 1'b1;
        alusrcb   = 2'b01;
        irwrite   = mem_ready;
        w_pcwrite = mem_ready;
        w_next    = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        if (op == OP_LW || op == OP_SW)         w_next = S_MEMADR;
        else if (op == OP_RTYPE)                w_next = S_RTYPEEX;
        else if (op == OP_BEQ)                  w_next = S_BEQEX;
        else if (ENABLE_ADDI && op == OP_ADDI)  w_next = S_ADDIEX;
        else if (ENABLE_JUMP && op == OP_J)     w_next = S_JEX;
        else begin
          illegal_op = 1'b1;
          instr_done = 1'b1;
          w_next     = S_FETCH;
        end
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        w_next  = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        w_next  = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        memtoreg   = 1'b1;
        regwrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        mem_req    = 1'b1;
        memwrite   = 1'b1;
        iord       = 1'b1;
        instr_done = mem_ready;
        w_next     = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
        w_next  = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        regdst     = 1'b1;
        regwrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_BEQEX: begin
        alusrca    = 1'b1;
        aluop      = 2'b01;
        pcsrc      = 2'b01;
        w_branch   = 1'b1;
        instr_done = 1'b1;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        w_next  = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_JEX: begin
        pcsrc      = 2'b10;
        w_pcwrite  = 1'b1;
        instr_done = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
  end

  assign pcen  = w_pcwrite | (w_branch & zero);
  assign state = r_state;

endmodule

// File: tb/tb_mc_controller.sv
// tb/tb_mc_controller.sv - directed self-checking bench for mc_controller
module tb_mc_controller;

  localparam logic [3:0] ST_RESET = 4'd0, ST_FETCH = 4'd1, ST_DECODE = 4'd2, ST_MEMADR = 4'd3;
  localparam logic [3:0] ST_MEMRD = 4'd4, ST_MEMWB = 4'd5, ST_MEMWR = 4'd6, ST_REX = 4'd7;
  localparam logic [3:0] ST_RWB = 4'd8, ST_BEQ = 4'd9, ST_AEX = 4'd10, ST_AWB = 4'd11, ST_JEX = 4'd12;

  // {mem_req,memwrite,iord,irwrite,alusrca,alusrcb,aluop,pcsrc,pcen,regdst,memtoreg,regwrite,instr_done,illegal_op}
  localparam logic [16:0] V_ZERO   = 17'b0_0_0_0_0_00_00_00_0_0_0_0_0_0;
  localparam logic [16:0] V_FETCH  = 17'b1_0_0_1_0_01_00_00_1_0_0_0_0_0;
  localparam logic [16:0] V_FETCHS = 17'b1_0_0_0_0_01_00_00_0_0_0_0_0_0;
  localparam logic [16:0] V_DEC    = 17'b0_0_0_0_0_11_00_00_0_0_0_0_0_0;
  localparam logic [16:0] V_DECILL = 17'b0_0_0_0_0_11_00_00_0_0_0_0_1_1;
  localparam logic [16:0] V_MADR   = 17'b0_0_0_0_1_10_00_00_0_0_0_0_0_0;
  localparam logic [16:0] V_MRD    = 17'b1_0_1_0_0_00_00_00_0_0_0_0_0_0;
  localparam logic [16:0] V_MWB    = 17'b0_0_0_0_0_00_00_00_0_0_1_1_1_0;
  localparam logic [16:0] V_MWRS   = 17'b1_1_1_0_0_00_00_00_0_0_0_0_0_0;
  localparam logic [16:0] V_MWR    = 17'b1_1_1_0_0_00_00_00_0_0_0_0_1_0;
  localparam logic [16:0] V_REX    = 17'b0_0_0_0_1_00_10_00_0_0_0_0_0_0;
  localparam logic [16:0] V_RWB    = 17'b0_0_0_0_0_00_00_00_0_1_0_1_1_0;
  localparam logic [16:0] V_BEQ1   = 17'b0_0_0_0_1_00_01_01_1_0_0_0_1_0;
  localparam logic [16:0] V_BEQ0   = 17'b0_0_0_0_1_00_01_01_0_0_0_0_1_0;
  localparam logic [16:0] V_AEX    = 17'b0_0_0_0_1_10_00_00_0_0_0_0_0_0;
  localparam logic [16:0] V_AWB    = 17'b0_0_0_0_0_00_00_00_0_0_0_1_1_0;
  localparam logic [16:0] V_JEX    = 17'b0_0_0_0_0_00_00_10_1_0_0_0_1_0;

  localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_R = 6'b000000;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;

  logic clk, rst_n, rst_n_nj, zero, mem_ready;
  logic [5:0] op;
  logic mem_req, memwrite, iord, irwrite, alusrca, pcen, regdst, memtoreg, regwrite, instr_done, illegal_op;
  logic [1:0] alusrcb, aluop, pcsrc;
  logic [3:0] state;
  logic mem_req_n, memwrite_n, iord_n, irwrite_n, alusrca_n, pcen_n, regdst_n, memtoreg_n, regwrite_n;
  logic instr_done_n, illegal_op_n;
  logic [1:0] alusrcb_n, aluop_n, pcsrc_n;
  logic [3:0] state_n;
  logic [16:0] vec, vec_n;
  int total, bad;

  mc_controller dut (
    .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .memwrite(memwrite), .iord(iord), .irwrite(irwrite), .alusrca(alusrca),
    .alusrcb(alusrcb), .aluop(aluop), .pcsrc(pcsrc), .pcen(pcen), .regdst(regdst),
    .memtoreg(memtoreg), .regwrite(regwrite), .instr_done(instr_done), .illegal_op(illegal_op),
    .state(state)
  );

  mc_controller #(.ENABLE_ADDI(1'b1), .ENABLE_JUMP(1'b0)) dut_nj (
    .clk(clk), .rst_n(rst_n_nj), .op(op), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req_n), .memwrite(memwrite_n), .iord(iord_n), .irwrite(irwrite_n), .alusrca(alusrca_n),
    .alusrcb(alusrcb_n), .aluop(aluop_n), .pcsrc(pcsrc_n), .pcen(pcen_n), .regdst(regdst_n),
    .memtoreg(memtoreg_n), .regwrite(regwrite_n), .instr_done(instr_done_n), .illegal_op(illegal_op_n),
    .state(state_n)
  );

  assign vec = {mem_req, memwrite, iord, irwrite, alusrca, alusrcb, aluop, pcsrc,
                pcen, regdst, memtoreg, regwrite, instr_done, illegal_op};
  assign vec_n = {mem_req_n, memwrite_n, iord_n, irwrite_n, alusrca_n, alusrcb_n, aluop_n, pcsrc_n,
                  pcen_n, regdst_n, memtoreg_n, regwrite_n, instr_done_n, illegal_op_n};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rst_n_nj = 1'b0; op = OP_LW; zero = 1'b0; mem_ready = 1'b1;
    step(); step();
    total++; if (state !== ST_RESET) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", state, ST_RESET); end
    total++; if (vec !== V_ZERO) begin bad++; $display("FAIL reset_outs got=%b exp=%b", vec, V_ZERO); end
    rst_n = 1'b1; #1;
    total++; if (state !== ST_RESET) begin bad++; $display("FAIL release_state got=%0d exp=%0d", state, ST_RESET); end
    step();
  endtask

  task automatic test_lw();
    logic [3:0]  es[5] = '{ST_FETCH, ST_DECODE, ST_MEMADR, ST_MEMRD, ST_MEMWB};
    logic [16:0] ev[5] = '{V_FETCH, V_DEC, V_MADR, V_MRD, V_MWB};
    int dn = 0;
    op = OP_LW; mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++; if (state !== es[i]) begin bad++; $display("FAIL lw_state c%0d got=%0d exp=%0d", i, state, es[i]); end
      total++; if (vec !== ev[i]) begin bad++; $display("FAIL lw_outs c%0d got=%b exp=%b", i, vec, ev[i]); end
      if (instr_done) dn++;
      step();
    end
    total++; if (dn != 1) begin bad++; $display("FAIL lw_done_count got=%0d exp=1", dn); end
  endtask

  task automatic test_sw_stall();
    logic [3:0]  es[7] = '{ST_FETCH, ST_DECODE, ST_MEMADR, ST_MEMWR, ST_MEMWR, ST_MEMWR, ST_MEMWR};
    logic [16:0] ev[7] = '{V_FETCH, V_DEC, V_MADR, V_MWRS, V_MWRS, V_MWRS, V_MWR};
    logic        mr[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    int wr = 0, rw = 0;
    op = OP_SW;
    for (int i = 0; i < 7; i++) begin
      mem_ready = mr[i]; #1;
      total++; if (state !== es[i]) begin bad++; $display("FAIL sw_state c%0d got=%0d exp=%0d", i, state, es[i]); end
      total++; if (vec !== ev[i]) begin bad++; $display("FAIL sw_outs c%0d got=%b exp=%b", i, vec, ev[i]); end
      if (memwrite && mem_req) wr++;
      if (regwrite) rw++;
      step();
    end
    total++; if (wr != 4) begin bad++; $display("FAIL sw_memwrite_cycles got=%0d exp=4", wr); end
    total++; if (rw != 0) begin bad++; $display("FAIL sw_regwrite_cycles got=%0d exp=0", rw); end
    mem_ready = 1'b1;
  endtask

  task automatic test_beq();
    logic [3:0]  es[6] = '{ST_FETCH, ST_DECODE, ST_BEQ, ST_FETCH, ST_DECODE, ST_BEQ};
    logic [16:0] ev[6] = '{V_FETCH, V_DEC, V_BEQ1, V_FETCH, V_DEC, V_BEQ0};
    logic        zz[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    op = OP_BEQ; mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      zero = zz[i]; #1;
      total++; if (state !== es[i]) begin bad++; $display("FAIL beq_state c%0d got=%0d exp=%0d", i, state, es[i]); end
      total++; if (vec !== ev[i]) begin bad++; $display("FAIL beq_outs c%0d got=%b exp=%b", i, vec, ev[i]); end
      step();
    end
    zero = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [3:0]  es[8] = '{ST_FETCH, ST_DECODE, ST_REX, ST_RWB, ST_FETCH, ST_DECODE, ST_AEX, ST_AWB};
    logic [16:0] ev[8] = '{V_FETCH, V_DEC, V_REX, V_RWB, V_FETCH, V_DEC, V_AEX, V_AWB};
    logic [5:0]  oo[8] = '{OP_R, OP_R, OP_R, OP_R, OP_ADDI, OP_ADDI, OP_ADDI, OP_ADDI};
    mem_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      op = oo[i]; #1;
      total++; if (state !== es[i]) begin bad++; $display("FAIL b2b_state c%0d got=%0d exp=%0d", i, state, es[i]); end
      total++; if (vec !== ev[i]) begin bad++; $display("FAIL b2b_outs c%0d got=%b exp=%b", i, vec, ev[i]); end
      step();
    end
  endtask

  task automatic test_jump();
    logic [3:0]  es[3] = '{ST_FETCH, ST_DECODE, ST_JEX};
    logic [16:0] ev[3] = '{V_FETCH, V_DEC, V_JEX};
    op = OP_J; mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (state !== es[i]) begin bad++; $display("FAIL j_state c%0d got=%0d exp=%0d", i, state, es[i]); end
      total++; if (vec !== ev[i]) begin bad++; $display("FAIL j_outs c%0d got=%b exp=%b", i, vec, ev[i]); end
      step();
    end
    total++; if (state !== ST_FETCH) begin bad++; $display("FAIL j_next got=%0d exp=%0d", state, ST_FETCH); end
  endtask

  task automatic test_illegal();
    op = 6'b111111; mem_ready = 1'b1; #1;
    total++; if (vec !== V_FETCH) begin bad++; $display("FAIL ill_fetch got=%b exp=%b", vec, V_FETCH); end
    step();
    total++; if (state !== ST_DECODE) begin bad++; $display("FAIL ill_state got=%0d exp=%0d", state, ST_DECODE); end
    total++; if (vec !== V_DECILL) begin bad++; $display("FAIL ill_outs got=%b exp=%b", vec, V_DECILL); end
    step();
    total++; if (state !== ST_FETCH) begin bad++; $display("FAIL ill_next got=%0d exp=%0d", state, ST_FETCH); end
    total++; if (illegal_op !== 1'b0) begin bad++; $display("FAIL ill_pulse_len got=%b exp=0", illegal_op); end
  endtask

  task automatic test_reset_mid();
    op = OP_SW; mem_ready = 1'b1;
    step(); step(); step();
    mem_ready = 1'b0; #1;
    total++; if (vec !== V_MWRS) begin bad++; $display("FAIL rm_memwr got=%b exp=%b", vec, V_MWRS); end
    #1 rst_n = 1'b0; #1;
    total++; if (state !== ST_RESET) begin bad++; $display("FAIL rm_async_state got=%0d exp=%0d", state, ST_RESET); end
    total++; if (vec !== V_ZERO) begin bad++; $display("FAIL rm_async_outs got=%b exp=%b", vec, V_ZERO); end
    step();
    rst_n = 1'b1;
    step(); #1;
    total++; if (state !== ST_FETCH) begin bad++; $display("FAIL rm_refetch got=%0d exp=%0d", state, ST_FETCH); end
    total++; if (vec !== V_FETCHS) begin bad++; $display("FAIL rm_stall_outs got=%b exp=%b", vec, V_FETCHS); end
    step();
    total++; if (state !== ST_FETCH) begin bad++; $display("FAIL rm_stall_hold got=%0d exp=%0d", state, ST_FETCH); end
    mem_ready = 1'b1; #1;
    total++; if (vec !== V_FETCH) begin bad++; $display("FAIL rm_fetch_ready got=%b exp=%b", vec, V_FETCH); end
    rst_n = 1'b0; #1;
    total++; if (vec !== V_ZERO) begin bad++; $display("FAIL rm_fetch_async got=%b exp=%b", vec, V_ZERO); end
    step();
    rst_n = 1'b1;
    step();
    total++; if (state !== ST_FETCH) begin bad++; $display("FAIL rm_refetch2 got=%0d exp=%0d", state, ST_FETCH); end
  endtask

  task automatic test_no_jump();
    op = OP_J; mem_ready = 1'b1; rst_n_nj = 1'b1;
    step(); #1;
    total++; if (state_n !== ST_FETCH) begin bad++; $display("FAIL nj_fetch got=%0d exp=%0d", state_n, ST_FETCH); end
    step();
    total++; if (state_n !== ST_DECODE) begin bad++; $display("FAIL nj_state got=%0d exp=%0d", state_n, ST_DECODE); end
    total++; if (vec_n !== V_DECILL) begin bad++; $display("FAIL nj_outs got=%b exp=%b", vec_n, V_DECILL); end
    step();
    total++; if (state_n !== ST_FETCH) begin bad++; $display("FAIL nj_next got=%0d exp=%0d", state_n, ST_FETCH); end
  endtask

  initial begin
    total = 0; bad = 0;
    test_reset();
    test_lw();
    test_sw_stall();
    test_beq();
    test_back_to_back();
    test_jump();
    test_illegal();
    test_reset_mid();
    test_no_jump();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
